// File: rtl/flatten_streamer_pkg.sv
// Shared types and constants for the flatten_streamer block.
package flatten_streamer_pkg;

  localparam int STATE_W    = 2;
  localparam int FIFO_DEPTH = 2;
  localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    STREAM,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/flatten_streamer_if.sv
// RAM read port plus the valid/hold activation stream toward the FC layer.
interface flatten_streamer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                  ram_rden_o;
  logic [ADDR_WIDTH-1:0] ram_rdaddress_o;
  logic [DATA_WIDTH-1:0] ram_data_i;
  logic [DATA_WIDTH-1:0] data_o;
  logic                  data_valid_o;
  logic                  hold_i;

  modport master (
    output ram_rden_o, ram_rdaddress_o, data_o, data_valid_o,
    input  ram_data_i, hold_i
  );

  modport slave (
    input  ram_rden_o, ram_rdaddress_o, data_o, data_valid_o,
    output ram_data_i, hold_i
  );
endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry skid FIFO; head and valid come straight from registers.
module stream_skid_buffer
  import flatten_streamer_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  valid,
  output logic [OCC_W-1:0]      occupancy
);

  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic [OCC_W-1:0]      occ_q;
  logic                  do_pop;

  assign do_pop = pop && (occ_q != '0);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      // NOTE: storage is reset too because the head register drives data_o,
      // which must read zero out of reset.
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (occ_q == '0) head_q <= push_data;
          else             tail_q <= push_data;
          occ_q <= occ_q + OCC_W'(1);
        end
        2'b01: begin
          head_q <= tail_q;
          occ_q  <= occ_q - OCC_W'(1);
        end
        2'b11: begin
          // Simultaneous push/pop: occupancy holds, order is kept.
          if (occ_q == OCC_W'(1)) begin
            head_q <= push_data;
          end else begin
            head_q <= tail_q;
            tail_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head      = head_q;
  assign valid     = (occ_q != '0);
  assign occupancy = occ_q;

endmodule

// File: rtl/flatten_streamer.sv
// Streams N_INPUTS activations from the flattened feature-map RAM to the FC layer.
// Optional: define FLATTEN_STREAMER_RELU_EN to clamp negative words to zero on FIFO write.
module flatten_streamer
  import flatten_streamer_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int BASE_ADDR  = 0,
  parameter int DATA_WIDTH = 32,
  parameter int N_INPUTS   = 64
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               start_i,
  flatten_streamer_if.master bus,
  output logic               busy_o,
  output logic               done_o
);

  localparam int             CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_INPUTS);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      issue_cnt_q, xfer_cnt_q, xfer_cnt_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  inflight_q;
  logic                  rden;
  logic                  pop;
  logic [OCC_W-1:0]      occupancy;
  logic [2:0]            level;
  logic [DATA_WIDTH-1:0] push_data;

  assign pop           = bus.data_valid_o & ~bus.hold_i;
  assign level         = 3'(occupancy) + 3'(inflight_q) - 3'(pop);
  assign xfer_cnt_next = xfer_cnt_q + CNT_W'(pop);

  always_comb begin
    // NOTE: defaults first so every path assigns every output (no latches).
    state_d = state_q;
    rden    = 1'b0;
    unique case (state_q)
      IDLE:   if (start_i) state_d = STREAM;
      STREAM: begin
        if (issue_cnt_q == N_CNT) state_d = DRAIN;
        else if (level < 3'd2)    rden    = 1'b1;
      end
      DRAIN:  if (xfer_cnt_next == N_CNT) state_d = DONE;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      xfer_cnt_q  <= '0;
      addr_q      <= ADDR_WIDTH'(BASE_ADDR);
      inflight_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rden;
      if (state_q == DONE) begin
        issue_cnt_q <= '0;
        xfer_cnt_q  <= '0;
        addr_q      <= ADDR_WIDTH'(BASE_ADDR);
      end else begin
        if (rden) begin
          issue_cnt_q <= issue_cnt_q + CNT_W'(1);
          addr_q      <= addr_q + ADDR_WIDTH'(1);
        end
        if (pop) xfer_cnt_q <= xfer_cnt_next;
      end
    end
  end

`ifdef FLATTEN_STREAMER_RELU_EN
  assign push_data = bus.ram_data_i[DATA_WIDTH-1] ? '0 : bus.ram_data_i;
`else
  assign push_data = bus.ram_data_i;
`endif

  stream_skid_buffer #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .push      (inflight_q),
    .pop       (pop),
    .push_data (push_data),
    .head      (bus.data_o),
    .valid     (bus.data_valid_o),
    .occupancy (occupancy)
  );

  assign bus.ram_rden_o      = rden;
  assign bus.ram_rdaddress_o = addr_q;
  assign busy_o              = (state_q == STREAM) || (state_q == DRAIN);
  assign done_o              = (state_q == DONE);

endmodule

// File: tb/tb_flatten_streamer.sv
// Directed bench for flatten_streamer: N_INPUTS=4, BASE_ADDR=0x100, one-cycle-latency RAM model.
module tb_flatten_streamer;

  localparam int NCYC = 30;

  logic clock_i = 1'b0;
  logic reset_i;
  logic start_i;
  logic busy_o;
  logic done_o;

  flatten_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

  flatten_streamer #(
    .ADDR_WIDTH (16),
    .BASE_ADDR  (16'h100),
    .DATA_WIDTH (32),
    .N_INPUTS   (4)
  ) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .bus     (bus.master),
    .busy_o  (busy_o),
    .done_o  (done_o)
  );

  always #5 clock_i = ~clock_i;

  // RAM: read data appears the cycle after the strobe.
  logic [31:0] mem [4];
  logic [15:0] ram_off;
  assign ram_off = bus.ram_rdaddress_o - 16'h100;
  always @(posedge clock_i) if (bus.ram_rden_o) bus.ram_data_i <= mem[ram_off[1:0]];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic        rden_a  [NCYC];
  logic [15:0] addr_a  [NCYC];
  logic        valid_a [NCYC];
  logic [31:0] data_a  [NCYC];
  logic        done_a  [NCYC];
  logic        busy_a  [NCYC];
  logic [31:0] xfer_q [$];
  int          done_cnt;
  int          rden_cnt;

  // Cycle 0 is the cycle start_vec[0] is presented; samples taken 1 ns after each negedge.
  task automatic run_pass(input logic [NCYC-1:0] start_vec, input logic [NCYC-1:0] hold_vec);
    xfer_q.delete();
    done_cnt = 0;
    rden_cnt = 0;
    for (int c = 0; c < NCYC; c++) begin
      @(negedge clock_i);
      start_i    = start_vec[c];
      bus.hold_i = hold_vec[c];
      #1;
      rden_a[c]  = bus.ram_rden_o;
      addr_a[c]  = bus.ram_rdaddress_o;
      valid_a[c] = bus.data_valid_o;
      data_a[c]  = bus.data_o;
      done_a[c]  = done_o;
      busy_a[c]  = busy_o;
      if (bus.data_valid_o && !bus.hold_i) xfer_q.push_back(bus.data_o);
      if (bus.ram_rden_o) rden_cnt++;
      if (done_o) done_cnt++;
    end
    @(negedge clock_i);
    start_i    = 1'b0;
    bus.hold_i = 1'b0;
  endtask

  task automatic check_xfers(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
    logic [31:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({tag, "_count"}, 64'(xfer_q.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      if (i < xfer_q.size()) check($sformatf("%s_w%0d", tag, i), 64'(xfer_q[i]), 64'(e[i]));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rden"},  64'(bus.ram_rden_o),      64'd0);
    check({tag, "_addr"},  64'(bus.ram_rdaddress_o), 64'h100);
    check({tag, "_valid"}, 64'(bus.data_valid_o),    64'd0);
    check({tag, "_data"},  64'(bus.data_o),          64'd0);
    check({tag, "_busy"},  64'(busy_o),              64'd0);
    check({tag, "_done"},  64'(done_o),              64'd0);
  endtask

  initial begin
    start_i    = 1'b0;
    bus.hold_i = 1'b0;
    reset_i    = 1'b1;
    mem[0] = 32'd10; mem[1] = 32'd20; mem[2] = 32'd30; mem[3] = 32'd40;

    // Reset state
    repeat (3) @(negedge clock_i);
    #1;
    check_reset_values("rst");
    reset_i = 1'b0;

    // Free-running pass: reads at cycles 1-4, data at cycles 3-6, done at cycle 7
    run_pass(NCYC'(1), '0);
    for (int c = 1; c <= 4; c++) begin
      check($sformatf("t1_rden_c%0d", c), 64'(rden_a[c]), 64'd1);
      check($sformatf("t1_addr_c%0d", c), 64'(addr_a[c]), 64'(16'h100 + 16'(c - 1)));
    end
    check("t1_rden_c5", 64'(rden_a[5]), 64'd0);
    check("t1_valid_c2", 64'(valid_a[2]), 64'd0);
    for (int c = 3; c <= 6; c++) begin
      check($sformatf("t1_valid_c%0d", c), 64'(valid_a[c]), 64'd1);
      check($sformatf("t1_data_c%0d", c), 64'(data_a[c]), 64'(10 * (c - 2)));
    end
    check("t1_busy_c1", 64'(busy_a[1]), 64'd1);
    check("t1_done_c6", 64'(done_a[6]), 64'd0);
    check("t1_done_c7", 64'(done_a[7]), 64'd1);
    check("t1_busy_c7", 64'(busy_a[7]), 64'd0);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);
    check("t1_addr_c8", 64'(addr_a[8]), 64'h100);
    check_xfers("t1", 32'd10, 32'd20, 32'd30, 32'd40);

    // hold_i high in cycles 4-7: head stays at 20, no extra reads
    run_pass(NCYC'(1), NCYC'('h0F0));
    for (int c = 4; c <= 7; c++) begin
      check($sformatf("t2_valid_c%0d", c), 64'(valid_a[c]), 64'd1);
      check($sformatf("t2_data_c%0d", c), 64'(data_a[c]), 64'd20);
    end
    for (int c = 4; c <= 7; c++)
      check($sformatf("t2_rden_c%0d", c), 64'(rden_a[c]), 64'd0);
    check("t2_rden_c8", 64'(rden_a[8]), 64'd1);
    check("t2_addr_c8", 64'(addr_a[8]), 64'h103);
    check("t2_rden_cnt", 64'(rden_cnt), 64'd4);
    check("t2_done_c11", 64'(done_a[11]), 64'd1);
    check("t2_done_cnt", 64'(done_cnt), 64'd1);
    check_xfers("t2", 32'd10, 32'd20, 32'd30, 32'd40);

    // hold_i toggling: high on even cycles, low on odd cycles
    run_pass(NCYC'(1), NCYC'('h1555_5555));
    check("t3_rden_c4", 64'(rden_a[4]), 64'd0);
    check("t3_addr_c5", 64'(addr_a[5]), 64'h103);
    check("t3_done_c10", 64'(done_a[10]), 64'd1);
    check("t3_done_cnt", 64'(done_cnt), 64'd1);
    check_xfers("t3", 32'd10, 32'd20, 32'd30, 32'd40);

    // Reset after two transfers, then a fresh pass
    @(negedge clock_i);
    start_i = 1'b1;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (4) @(negedge clock_i);
    #1;
    check("t4_pre_data", 64'(bus.data_o), 64'd30);
    reset_i = 1'b1;
    @(negedge clock_i);
    reset_i = 1'b0;
    #1;
    check_reset_values("t4_rst");
    run_pass(NCYC'(1), '0);
    check("t4_done_c7", 64'(done_a[7]), 64'd1);
    check_xfers("t4", 32'd10, 32'd20, 32'd30, 32'd40);

    // start_i while busy (cycle 3) and during DONE (cycle 7) is ignored
    run_pass(NCYC'('h89), '0);
    check("t5_done_cnt", 64'(done_cnt), 64'd1);
    check("t5_rden_cnt", 64'(rden_cnt), 64'd4);
    check("t5_busy_c8", 64'(busy_a[8]), 64'd0);
    check("t5_rden_c8", 64'(rden_a[8]), 64'd0);
    check_xfers("t5", 32'd10, 32'd20, 32'd30, 32'd40);

    // start_i in the cycle after DONE begins a new pass
    run_pass(NCYC'('h101), '0);
    check("t6_rden_c9", 64'(rden_a[9]), 64'd1);
    check("t6_addr_c9", 64'(addr_a[9]), 64'h100);
    check("t6_busy_c9", 64'(busy_a[9]), 64'd1);
    check("t6_done_c15", 64'(done_a[15]), 64'd1);
    check("t6_done_cnt", 64'(done_cnt), 64'd2);
    check("t6_xfer_cnt", 64'(xfer_q.size()), 64'd8);

    // Signed data: clamped to zero when the ReLU option is built in
    mem[0] = 32'hFFFF_FFFB; mem[1] = 32'd7; mem[2] = 32'h8000_0000; mem[3] = 32'd3;
    run_pass(NCYC'(1), '0);
`ifdef FLATTEN_STREAMER_RELU_EN
    check_xfers("t7_relu", 32'd0, 32'd7, 32'd0, 32'd3);
`else
    check_xfers("t7_pass", 32'hFFFF_FFFB, 32'd7, 32'h8000_0000, 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
